// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC selection, delayed-branch/exception redirect,
// fetch-wait handling and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic [31:0]        imem_instr,
    input  logic               imem_ready,
    input  logic               id_stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               exc_valid,
    input  logic [31:0]        exc_target,
    output logic [31:0]        npc,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_instr,
    output logic               id_valid,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam int unsigned XLEN      = 32;
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [XLEN-1:0]    pc4_c;
    logic [XLEN-1:0]    npc_raw_c;

    // Deferred branch redirect captured while the delay slot is still being fetched
    logic               pend_valid;
    logic [XLEN-1:0]    pend_target;

    logic               pend_valid_d;
    logic [XLEN-1:0]    pend_target_d;
    logic [XLEN-1:0]    id_pc_d;
    logic [XLEN-1:0]    id_pc4_d;
    logic [XLEN-1:0]    id_instr_d;
    logic               id_valid_d;
    logic [COUNT_W-1:0] fetch_count_d;

    assign pc4_c = pc + XLEN'(4);

    // Next-PC source selection by priority; low two bits always cleared
    always_comb begin
        npc_raw_c = pc4_c;
        if (rst) begin
            npc_raw_c = RESET_PC;
        end else if (exc_valid) begin
            npc_raw_c = exc_target;
        end else if (id_stall || !imem_ready) begin
            npc_raw_c = pc;
        end else if (pend_valid) begin
            npc_raw_c = pend_target;
        end else if (br_taken) begin
            npc_raw_c = br_target;
        end
    end

    assign npc = npc_raw_c & WORD_MASK;

    // Next values for IF/ID, pending redirect and fetch counter
    always_comb begin
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        id_pc_d       = id_pc;
        id_pc4_d      = id_pc4;
        id_instr_d    = id_instr;
        id_valid_d    = id_valid;
        fetch_count_d = fetch_count;

        if (exc_valid) begin
            id_instr_d   = '0;
            id_valid_d   = 1'b0;
            pend_valid_d = 1'b0;
        end else if (id_stall) begin
            // hold everything; hazard unit re-asserts any branch later
        end else if (!imem_ready) begin
            id_instr_d = '0;
            id_valid_d = 1'b0;
            if (br_taken) begin
                pend_valid_d  = 1'b1;
                pend_target_d = br_target;
            end
        end else begin
            id_pc_d       = pc;
            id_pc4_d      = pc4_c;
            id_instr_d    = imem_instr;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count + COUNT_W'(1);
            pend_valid_d  = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_target <= '0;
            id_pc       <= RESET_PC;
            id_pc4      <= RESET_PC + XLEN'(4);
            id_instr    <= '0;
            id_valid    <= 1'b0;
            fetch_count <= '0;
        end else begin
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
            id_pc       <= id_pc_d;
            id_pc4      <= id_pc4_d;
            id_instr    <= id_instr_d;
            id_valid    <= id_valid_d;
            fetch_count <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage with hand-computed expectations.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] imem_instr;
    logic        imem_ready;
    logic        id_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic [31:0] npc;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.RESET_PC(32'h0040_0000), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc(pc), .imem_instr(imem_instr),
        .imem_ready(imem_ready), .id_stall(id_stall), .br_taken(br_taken),
        .br_target(br_target), .exc_valid(exc_valid), .exc_target(exc_target),
        .npc(npc), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
        .id_valid(id_valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0040_0000; imem_instr = 32'h1111_1111; imem_ready = 1'b1;
        id_stall = 1'b0; br_taken = 1'b0; br_target = '0; exc_valid = 1'b0; exc_target = '0;

        // Reset held two cycles
        #1;
        check("rst_npc", npc, 32'h0040_0000);
        tick();
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_instr", id_instr, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_idpc", id_pc, 32'h0040_0000);
        check("rst_idpc4", id_pc4, 32'h0040_0004);
        tick();
        check("rst2_valid", {31'd0, id_valid}, 32'd0);

        // Release: first fetch
        rst = 1'b0; imem_instr = 32'hA000_0000;
        #1;
        check("rel_npc", npc, 32'h0040_0004);
        tick();
        check("rel_idpc", id_pc, 32'h0040_0000);
        check("rel_valid", {31'd0, id_valid}, 32'd1);
        check("rel_instr", id_instr, 32'hA000_0000);
        check("rel_count", fetch_count, 32'd1);

        // Sequential fetch wrapping past the top of the address space
        pc = 32'hFFFF_FFFC; imem_instr = 32'hA100_0001;
        #1;
        check("wrap_npc", npc, 32'h0000_0000);
        tick();
        check("wrap_idpc4", id_pc4, 32'h0000_0000);
        check("wrap_idpc", id_pc, 32'hFFFF_FFFC);
        check("wrap_count", fetch_count, 32'd2);

        // Delayed branch, misaligned target bits masked
        pc = 32'h0040_0010; imem_instr = 32'hA200_0002; br_taken = 1'b1; br_target = 32'h0040_0103;
        #1;
        check("br_npc", npc, 32'h0040_0100);
        tick();
        check("br_slot_pc", id_pc, 32'h0040_0010);
        check("br_slot_valid", {31'd0, id_valid}, 32'd1);
        check("br_slot_instr", id_instr, 32'hA200_0002);
        check("br_count", fetch_count, 32'd3);
        pc = 32'h0040_0100; imem_instr = 32'hA300_0003; br_taken = 1'b0;
        #1;
        check("br_tgt_npc", npc, 32'h0040_0104);
        tick();
        check("br_tgt_idpc", id_pc, 32'h0040_0100);

        // Branch arrives during a fetch wait, wait lasts 3 more cycles
        pc = 32'h0040_0104; imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0200;
        #1;
        check("wbr_npc", npc, 32'h0040_0104);
        tick();
        check("wbr_valid", {31'd0, id_valid}, 32'd0);
        check("wbr_instr", id_instr, 32'd0);
        check("wbr_count", fetch_count, 32'd4);
        br_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_npc", npc, 32'h0040_0104);
            tick();
            check("wait_valid", {31'd0, id_valid}, 32'd0);
        end
        // Completion: pending target wins over a simultaneous new branch
        imem_ready = 1'b1; imem_instr = 32'hA400_0004; br_taken = 1'b1; br_target = 32'h0040_0500;
        #1;
        check("wdone_npc", npc, 32'h0040_0200);
        tick();
        check("wdone_idpc", id_pc, 32'h0040_0104);
        check("wdone_valid", {31'd0, id_valid}, 32'd1);
        check("wdone_instr", id_instr, 32'hA400_0004);
        check("wdone_count", fetch_count, 32'd5);
        pc = 32'h0040_0200; imem_instr = 32'hA500_0005; br_taken = 1'b0;
        #1;
        check("pend_clr_npc", npc, 32'h0040_0204);
        tick();
        check("pend_clr_count", fetch_count, 32'd6);

        // Stall three cycles with an exception in the second
        pc = 32'h0040_0204; id_stall = 1'b1; br_taken = 1'b1; br_target = 32'h0040_0600;
        #1;
        check("st1_npc", npc, 32'h0040_0204);
        tick();
        check("st1_idpc", id_pc, 32'h0040_0200);
        check("st1_valid", {31'd0, id_valid}, 32'd1);
        check("st1_count", fetch_count, 32'd6);
        br_taken = 1'b0; exc_valid = 1'b1; exc_target = 32'h0040_0004;
        #1;
        check("st2_npc", npc, 32'h0040_0004);
        tick();
        check("st2_valid", {31'd0, id_valid}, 32'd0);
        check("st2_instr", id_instr, 32'd0);
        check("st2_idpc", id_pc, 32'h0040_0200);
        exc_valid = 1'b0; pc = 32'h0040_0004;
        #1;
        check("st3_npc", npc, 32'h0040_0004);
        tick();
        check("st3_count", fetch_count, 32'd6);
        id_stall = 1'b0; imem_instr = 32'hA600_0006;
        #1;
        check("exc_fetch_npc", npc, 32'h0040_0008);
        tick();
        check("exc_fetch_idpc", id_pc, 32'h0040_0004);
        check("exc_fetch_count", fetch_count, 32'd7);

        // Pending redirect discarded by an exception during the wait
        pc = 32'h0040_0008; imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0300;
        tick();
        br_taken = 1'b0; exc_valid = 1'b1; exc_target = 32'h0040_0080;
        #1;
        check("pexc_npc", npc, 32'h0040_0080);
        tick();
        check("pexc_valid", {31'd0, id_valid}, 32'd0);
        exc_valid = 1'b0; pc = 32'h0040_0080; imem_ready = 1'b1; imem_instr = 32'hA700_0007;
        #1;
        check("pexc_next_npc", npc, 32'h0040_0084);
        tick();
        check("pexc_idpc", id_pc, 32'h0040_0080);
        check("pexc_count", fetch_count, 32'd8);

        // Reset while a redirect is pending returns to a clean state
        pc = 32'h0040_0084; imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0400;
        tick();
        br_taken = 1'b0; rst = 1'b1;
        #1;
        check("prst_npc", npc, 32'h0040_0000);
        tick();
        check("prst_count", fetch_count, 32'd0);
        rst = 1'b0; pc = 32'h0040_0000; imem_ready = 1'b1; imem_instr = 32'hA800_0008;
        #1;
        check("prst_next_npc", npc, 32'h0040_0004);
        tick();
        check("prst_idpc", id_pc, 32'h0040_0000);
        check("prst_count1", fetch_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage controller of the pipelined MIPS CPU. It sits between the PC register and the decode stage. It computes the next PC presented to the PC register's `data_in`, applies stall, instruction-memory wait, delayed-branch and exception redirects, and holds the IF/ID pipeline register. Branches resolve in ID with one architectural delay slot.

## Interface
Parameters:
- `RESET_PC`, default 32'h00400000: boot address; reset value of `id_pc`.
- `COUNT_W`, default 32: width of the fetched-instruction counter.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `pc`  input  32: current PC from the PC register.
- `imem_instr`  input  32: instruction word at `pc`, combinational from instruction memory.
- `imem_ready`  input  1: `imem_instr` is valid this cycle.
- `id_stall`  input  1: hazard-unit stall; hold the PC and IF/ID.
- `br_taken`  input  1: taken branch or jump resolved in ID this cycle.
- `br_target`  input  32: branch or jump target.
- `exc_valid`  input  1: exception, `eret` or interrupt redirect from CP0.
- `exc_target`  input  32: exception handler or EPC target.
- `npc`  output  32: next PC, combinational; drives the PC register `data_in`.
- `id_pc`  output  32: PC of the instruction in IF/ID.
- `id_pc4`  output  32: `id_pc` + 4.
- `id_instr`  output  32: instruction in IF/ID; 0 (nop) when there is a bubble.
- `id_valid`  output  1: IF/ID holds a real instruction.
- `fetch_count`  output  COUNT_W: number of instructions delivered into IF/ID.

## Operation
Internal state is `pend_valid` and `pend_target` (32 bits), a deferred branch redirect. Each cycle is evaluated by strict priority:
1. **`rst`**
   - `npc` = RESET_PC.
   - IF/ID is loaded with `id_pc`=RESET_PC, `id_pc4`=RESET_PC+4, `id_instr`=0, `id_valid`=0.
   - `pend_valid` and `fetch_count` are cleared to 0.
2. **`exc_valid`** (overrides stall and wait)
   - `npc` = `exc_target`.
   - IF/ID is loaded with a bubble: `id_valid`=0, `id_instr`=0; `id_pc` and `id_pc4` hold.
   - `pend_valid` is cleared.
3. **`id_stall`**
   - `npc` = `pc`.
   - IF/ID, the pending state and the counter all hold.
   - `br_taken` is ignored; the hazard unit re-asserts it once the stall releases.
4. **`!imem_ready`** (fetch wait)
   - `npc` = `pc`.
   - IF/ID is loaded with a bubble.
   - If `br_taken` is high, the delay slot is not yet fetched: set `pend_valid`=1 and `pend_target`=`br_target`.
5. **Fetch completes**
   - IF/ID is loaded with `id_pc`=`pc`, `id_pc4`=`pc`+4, `id_instr`=`imem_instr`, `id_valid`=1.
   - `fetch_count` increments.
   - `npc` is selected in this order:
     - `pend_target` if `pend_valid`; `pend_valid` is then cleared.
     - else `br_target` if `br_taken`.
     - else `pc`+4.
   - If `pend_valid` and `br_taken` are both high, the pending target wins and `br_taken` is dropped.

Width and arithmetic rules:
- `pc`+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Bits [1:0] of `npc` are forced to 0 for every source.
- `fetch_count` wraps modulo 2^COUNT_W.

## Timing
- `npc` is purely combinational from the inputs and pending state, with zero cycle latency. The PC register captures it on the same edge that IF/ID updates.
- IF/ID has 1 cycle latency: the instruction at `pc` in cycle N appears on `id_*` in cycle N+1.
- Delay slot:
  - When `br_taken` is high in cycle N and the fetch completes, the instruction fetched in cycle N is the delay slot and is delivered with `id_valid`=1.
  - The branch target is fetched in cycle N+1.
- Deferred redirect: after `br_taken` arrives during a wait, the redirect takes effect in the cycle the delay-slot fetch completes. This holds for any wait length.
- Exception vs. pending redirect: an exception in any cycle discards the pending redirect. The next fetch is from `exc_target`.
- Reset mid-wait or mid-pending: the next cycle is in the clean reset state. There is no partial redirect.

## Test plan
- **Reset.** Stimulus: hold `rst` 2 cycles with `imem_ready`=1, then release. Required response:
  - During reset: `npc`=32'h00400000, `id_valid`=0, `id_instr`=0, `fetch_count`=0.
  - After release: `npc`=32'h00400004 and `id_pc`=32'h00400000 with `id_valid`=1.
- **Sequential fetch with wrap.** Stimulus: drive `pc`=32'hFFFFFFFC with `imem_ready`=1. Required response: `npc`=0, `id_pc4`=0, `fetch_count` increments by 1.
- **Delayed branch.** Stimulus: `pc`=32'h00400010, `br_taken`=1, `br_target`=32'h00400100. Required response:
  - `npc`=32'h00400100.
  - Next cycle: `id_pc`=32'h00400010 with `id_valid`=1, i.e. the delay slot is kept.
- **Branch during fetch wait.** Stimulus: `br_taken` pulses with `imem_ready`=0, then `imem_ready`=0 for 3 more cycles, then 1. Required response:
  - `npc`=`pc` and bubbles in IF/ID while waiting.
  - On the completing cycle: delay slot delivered and `npc`=`br_target`.
- **Stall vs. exception.** Stimulus: `id_stall`=1 for 3 cycles, with `exc_valid`=1 in the 2nd cycle (`exc_target`=32'h00400004). Required response:
  - Cycle 1: IF/ID and `fetch_count` hold.
  - Cycle 2: `npc`=32'h00400004, and `id_valid`=0 on the next edge.
- **Pending discarded by exception.** Stimulus: create a pending redirect, then assert `exc_valid` during the wait. Required response: the subsequent fetch starts at `exc_target`; `pend_target` is never used.
